// File: rtl/itof_pkg.sv
// Shared definitions for the integer-to-float converter: FSM state encoding,
// exponent constants and the round-to-nearest-even decision helper.
package itof_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } itof_state_e;

    localparam int FP_BIAS       = 127;
    localparam int ITOF_EXP_BASE = FP_BIAS + 31;

    // Round-to-nearest, ties-to-even: increment when above half, or exactly
    // half with an odd mantissa LSB.
    function automatic logic rne_round_up(input logic guard_bit,
                                          input logic sticky_bit,
                                          input logic lsb_bit);
        return guard_bit & (sticky_bit | lsb_bit);
    endfunction

endpackage

// File: rtl/itof_lzc32.sv
// Combinational 32-bit leading-zero counter with an all-zero flag.
// For an all-zero input the count reads 0; callers use the zero flag instead.
module lzc32 (
    input  logic [31:0] value,
    output logic [4:0]  count,
    output logic        zero
);

    // Scan upward so the most significant set bit makes the final assignment.
    always_comb begin
        count = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                count = 5'(31 - i);
            end else begin
                count = count;
            end
        end
    end

    assign zero = (value == 32'd0);

endmodule

// File: rtl/itof.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single-precision converter.
// IDLE captures the operand, NORM normalizes, RND rounds (nearest-even) and
// DONE presents a one-cycle done pulse. Optional macro ITOF_UNSIGNED_EN adds
// the unsgn port for unsigned conversion.
module itof
    import itof_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        order,
    output logic        accepted,
    output logic        done,
    input  logic [31:0] rs1,
    output logic [31:0] rd
`ifdef ITOF_UNSIGNED_EN
    ,
    input  logic        unsgn
`endif
);

    itof_state_e state_r;
    logic [31:0] op_r;
    logic        sign_r;
    logic        zero_r;
    logic [4:0]  lz_r;
    logic [30:0] norm_r;
    logic [31:0] rd_r;
    logic        done_r;
`ifdef ITOF_UNSIGNED_EN
    logic        unsgn_r;
`endif

    logic        neg_s;
    logic [31:0] abs_s;
    logic [4:0]  lz_s;
    logic        zero_s;
    logic [30:0] norm_next_s;
    logic        round_up_s;
    logic [23:0] mant_inc_s;
    logic [22:0] mant_s;
    logic [7:0]  exp_s;

    assign accepted = order && (state_r == IDLE) && rstn;
    assign done     = done_r;
    assign rd       = rd_r;

    // Sign and magnitude of the captured operand; -0x80000000 wraps to itself.
    always_comb begin
`ifdef ITOF_UNSIGNED_EN
        neg_s = op_r[31] & ~unsgn_r;
`else
        neg_s = op_r[31];
`endif
        if (neg_s) begin
            abs_s = 32'd0 - op_r;
        end else begin
            abs_s = op_r;
        end
    end

    lzc32 u_lzc (
        .value (abs_s),
        .count (lz_s),
        .zero  (zero_s)
    );

    // The leading one (bit 31 after the shift) is implicit and not stored.
    assign norm_next_s = 31'(abs_s << lz_s);

    // Round the normalized magnitude; a mantissa carry-out bumps the exponent.
    always_comb begin
        round_up_s = rne_round_up(norm_r[7], |norm_r[6:0], norm_r[8]);
        mant_inc_s = {1'b0, norm_r[30:8]} + {23'd0, round_up_s};
        if (mant_inc_s[23]) begin
            mant_s = 23'd0;
            exp_s  = 8'(ITOF_EXP_BASE) - {3'd0, lz_r} + 8'd1;
        end else begin
            mant_s = mant_inc_s[22:0];
            exp_s  = 8'(ITOF_EXP_BASE) - {3'd0, lz_r};
        end
    end

    // Conversion FSM with registered result and done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            op_r    <= 32'd0;
            sign_r  <= 1'b0;
            zero_r  <= 1'b0;
            lz_r    <= 5'd0;
            norm_r  <= 31'd0;
            rd_r    <= 32'd0;
            done_r  <= 1'b0;
`ifdef ITOF_UNSIGNED_EN
            unsgn_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (order) begin
                        op_r    <= rs1;
`ifdef ITOF_UNSIGNED_EN
                        unsgn_r <= unsgn;
`endif
                        state_r <= NORM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                NORM: begin
                    sign_r  <= neg_s;
                    zero_r  <= zero_s;
                    lz_r    <= lz_s;
                    norm_r  <= norm_next_s;
                    state_r <= RND;
                end
                RND: begin
                    if (zero_r) begin
                        rd_r <= 32'd0;
                    end else begin
                        rd_r <= {sign_r, exp_s, mant_s};
                    end
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
